cmd_bus_initiator: RTL and testbench

//  Initiator side of the command bus: accepts one memory command from a local client, serializes it onto
//  the 8-bit command bus as {dest id, opcode, address}, and waits for the responder's acknowledgement.

---
 rtl/cmd_bus_initiator.sv | 173 +++++++++++++++++
 tb/tb_cmd_bus_initiator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cmd_bus_initiator.sv
// cmd_bus_initiator: takes one client memory command, sends it on the 8-bit command bus and waits for the ack.
// Optional feature macro: CMD_RETRY_EN resends the frame after a timeout or a responder error.
module cmd_bus_initiator #(
  parameter int unsigned ID_W        = 8,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ID_W-1:0] req_dest,
  input  logic [7:0]      req_opcode,
  input  logic [23:0]     req_addr,
  output logic [7:0]      bus_data,
  output logic            bus_valid,
  input  logic            bus_ready,
  input  logic            ack_valid,
  input  logic [ID_W-1:0] ack_id,
  input  logic            ack_err,
  output logic            busy,
  output logic            done,
  output logic [1:0]      status
);

  localparam int unsigned CNT_W   = $clog2(ACK_TIMEOUT);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_ER4K  = 8'h20;
  localparam logic [7:0] OP_ER32K = 8'h52;
  localparam logic [7:0] OP_ER64K = 8'hD8;
  localparam logic [7:0] OP_RESET = 8'h99;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;
  localparam logic [1:0] ST_ILL = 2'b11;

  // Parameter sanity check at elaboration.
  if (ID_W == 0 || ID_W > 8 || ACK_TIMEOUT < 2 || RETRY_W > 16) begin : g_param_check
    $error("cmd_bus_initiator: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ID, S_OP, S_A2, S_A1, S_A0, S_WAIT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   dest_q, dest_n;
  logic [7:0]        op_q, op_n;
  logic [23:0]       addr_q, addr_n;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        bus_data_d;
  logic              bus_valid_d, req_ready_d, busy_d, done_d;
  logic [1:0]        status_d, result;
  logic              accept, bus_hs, ack_hit, timeout;
`ifdef CMD_RETRY_EN
  logic [RETRY_W-1:0] retry_q;
  logic               retry_go;
`endif

  function automatic logic opcode_legal(input logic [7:0] op);
    return op inside {OP_WRITE, OP_READ, OP_ER4K, OP_ER32K, OP_ER64K, OP_RESET};
  endfunction

  assign accept  = req_valid & req_ready & (state_q == S_IDLE);
  assign bus_hs  = bus_valid & bus_ready;
  assign ack_hit = ack_valid & (ack_id == dest_q);
  assign timeout = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dest_q    <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      bus_data  <= '0;
      bus_valid <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= ST_OK;
`ifdef CMD_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_n;
      op_q      <= op_n;
      addr_q    <= addr_n;
      cnt_q     <= cnt_d;
      bus_data  <= bus_data_d;
      bus_valid <= bus_valid_d;
      req_ready <= req_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      status    <= status_d;
`ifdef CMD_RETRY_EN
      if (accept)        retry_q <= '0;
      else if (retry_go) retry_q <= RETRY_W'(retry_q + 1'b1);
`endif
    end
  end

  // Next state and completion code.
  always_comb begin
    state_d = state_q;
    result  = ST_OK;
`ifdef CMD_RETRY_EN
    retry_go = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: if (accept) begin
        if (opcode_legal(req_opcode)) begin
          state_d = S_ID;
        end else begin
          state_d = S_DONE;
          result  = ST_ILL;
        end
      end
      S_ID: if (bus_hs) state_d = S_OP;
      S_OP: if (bus_hs) state_d = (op_q == OP_RESET) ? S_WAIT : S_A2;
      S_A2: if (bus_hs) state_d = S_A1;
      S_A1: if (bus_hs) state_d = S_A0;
      S_A0: if (bus_hs) state_d = S_WAIT;
      S_WAIT: if (ack_hit || timeout) begin
        // A matching ack takes priority over a coincident timeout.
        result  = ack_hit ? (ack_err ? ST_ERR : ST_OK) : ST_TMO;
        state_d = S_DONE;
`ifdef CMD_RETRY_EN
        if (result != ST_OK && retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_go = 1'b1;
          state_d  = S_ID;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    dest_n = dest_q;
    op_n   = op_q;
    addr_n = addr_q;
    if (accept) begin
      dest_n = req_dest;
      op_n   = req_opcode;
      addr_n = req_addr;
    end
    bus_valid_d = 1'b0;
    bus_data_d  = '0;
    unique case (state_d)
      S_ID: begin bus_valid_d = 1'b1; bus_data_d = 8'(dest_n);     end
      S_OP: begin bus_valid_d = 1'b1; bus_data_d = op_n;           end
      S_A2: begin bus_valid_d = 1'b1; bus_data_d = addr_n[23:16];  end
      S_A1: begin bus_valid_d = 1'b1; bus_data_d = addr_n[15:8];   end
      S_A0: begin bus_valid_d = 1'b1; bus_data_d = addr_n[7:0];    end
      default: ;
    endcase
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    status_d    = (state_d == S_DONE) ? result : status;
    cnt_d       = (state_q == S_WAIT) ? CNT_W'(cnt_q + 1'b1) : '0;
  end

endmodule

// File: tb/tb_cmd_bus_initiator.sv
// tb_cmd_bus_initiator: directed and randomized commands checked against a frame/timing model of the initiator.
module tb_cmd_bus_initiator;

  localparam int unsigned ID_W        = 8;
  localparam int unsigned ACK_TIMEOUT = 16;
  localparam int unsigned MAX_RETRY   = 3;
  localparam int          T           = int'(ACK_TIMEOUT);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [7:0]  req_dest, req_opcode;
  logic [23:0] req_addr;
  logic [7:0]  bus_data;
  logic        bus_valid, bus_ready;
  logic        ack_valid, ack_err;
  logic [7:0]  ack_id;
  logic        busy, done;
  logic [1:0]  status;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  cmd_bus_initiator #(.ID_W(ID_W), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest),
    .req_opcode(req_opcode), .req_addr(req_addr),
    .bus_data(bus_data), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .ack_valid(ack_valid), .ack_id(ack_id), .ack_err(ack_err),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One client command with a scripted responder; ack_delay counts WAIT_ACK cycles from entry.
  task automatic run_cmd(input logic [7:0] dest, input logic [7:0] op, input logic [23:0] addr,
                         input int ack_delay, input bit err, input int mode,
                         input bit bad_ack, input bit hold);
    logic [7:0] frame[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] prev_data;
    logic [1:0] exp_st;
    bit legal, matched, in_wait, pend_last, prev_stall, finished;
    int n_att, exp_w, w, c, nbytes;

    legal   = op inside {8'h02, 8'h03, 8'h20, 8'h52, 8'hD8, 8'h99};
    matched = (ack_delay >= 0) && (ack_delay < T);
    if (!legal)       exp_st = 2'b11;
    else if (matched) exp_st = err ? 2'b01 : 2'b00;
    else              exp_st = 2'b10;
    exp_w = matched ? ack_delay + 1 : T;
    n_att = 1;
`ifdef CMD_RETRY_EN
    if (legal && exp_st != 2'b00) n_att = 1 + int'(MAX_RETRY);
`endif
    if (legal) begin
      frame.push_back(dest);
      frame.push_back(op);
      if (op != 8'h99) begin
        frame.push_back(addr[23:16]);
        frame.push_back(addr[15:8]);
        frame.push_back(addr[7:0]);
      end
    end
    for (int a = 0; a < n_att; a++)
      foreach (frame[i]) exp_q.push_back(frame[i]);

    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_dest = dest; req_opcode = op; req_addr = addr;
    bus_ready = 1'b0; ack_valid = 1'b0; ack_id = 8'h00; ack_err = 1'b0;
    step();
    if (!hold) req_valid = 1'b0;

    c = 0; w = 0; nbytes = 0; prev_data = 8'h00;
    in_wait = 0; pend_last = 0; prev_stall = 0; finished = 0;
    while (!finished && c < 2000) begin
      c++;
      if (pend_last) begin in_wait = 1; w = 0; pend_last = 0; end
      else if (in_wait) w++;
      if (bus_valid === 1'b1) in_wait = 0;
      if (done === 1'b1) begin
        finished = 1;
        if (legal) begin
          chk("done_after_wait", 32'(in_wait), 32'd1);
          chk("done_latency", 32'(w), 32'(exp_w));
        end else begin
          chk("illegal_done_latency", 32'(c), 32'd1);
        end
        chk("status_at_done", 32'(status), 32'(exp_st));
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("req_ready_at_done", 32'(req_ready), 32'd0);
        ack_valid = 1'b0;
        if (hold) req_valid = 1'b0;
      end else begin
        chk("busy", 32'(busy), 32'd1);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (prev_stall) begin
          chk("stall_valid", 32'(bus_valid), 32'd1);
          chk("stall_data", 32'(bus_data), 32'(prev_data));
        end
        if (in_wait && w == 0) chk("valid_drop", 32'(bus_valid), 32'd0);
        case (mode)
          0:       bus_ready = 1'b1;
          1:       bus_ready = (c % 3 == 1);
          default: bus_ready = 1'($urandom_range(0, 1));
        endcase
        ack_valid = 1'b0; ack_id = 8'h00; ack_err = 1'b0;
        if (bad_ack && c == 1) begin ack_valid = 1'b1; ack_id = dest; end
        if (in_wait) begin
          if (w == ack_delay) begin
            ack_valid = 1'b1; ack_id = dest; ack_err = err;
          end else if (bad_ack && w == 0) begin
            ack_valid = 1'b1; ack_id = dest ^ 8'h02; ack_err = 1'b0;
          end
        end
        if (bus_valid === 1'b1 && bus_ready) begin
          got_q.push_back(bus_data);
          nbytes++;
          if (frame.size() != 0 && nbytes % frame.size() == 0) pend_last = 1;
        end
        prev_stall = (bus_valid === 1'b1) && !bus_ready;
        prev_data  = bus_data;
        step();
      end
    end
    if (!finished) chk("done_never_seen", 32'd0, 32'd1);
    chk("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("frame_byte", 32'(got_q[i]), 32'(exp_q[i]));
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("req_ready_after_done", 32'(req_ready), 32'd1);
    chk("status_held", 32'(status), 32'(exp_st));
  endtask

  initial begin
    logic [7:0] ops [7];
    logic [7:0] op;
    rst_n = 1'b0; req_valid = 1'b0; req_dest = 8'h00; req_opcode = 8'h00; req_addr = 24'h0;
    bus_ready = 1'b0; ack_valid = 1'b0; ack_id = 8'h00; ack_err = 1'b0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_data", 32'(bus_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    run_cmd(8'h05, 8'h03, 24'h123456, 3, 1'b0, 0, 1'b0, 1'b0);
    run_cmd(8'h02, 8'h99, 24'hFFFFFF, 1, 1'b0, 0, 1'b0, 1'b0);
    run_cmd(8'h05, 8'h42, 24'h000001, 0, 1'b0, 0, 1'b0, 1'b0);
    run_cmd(8'h05, 8'h02, 24'hA5C3E1, -1, 1'b0, 1, 1'b1, 1'b0);
    run_cmd(8'h11, 8'hD8, 24'h0F0000, 2, 1'b1, 0, 1'b0, 1'b0);
    run_cmd(8'h33, 8'h20, 24'h001000, T - 1, 1'b0, 0, 1'b0, 1'b0);
    run_cmd(8'h44, 8'h52, 24'h080000, 0, 1'b0, 2, 1'b1, 1'b1);

    // Reset in the middle of a frame, while byte A1 is on the bus.
    req_valid = 1'b1; req_dest = 8'h05; req_opcode = 8'h03; req_addr = 24'hABCDEF; bus_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step(); step(); step();
    chk("a1_byte", 32'(bus_data), 32'h0000_00CD);
    #2 rst_n = 1'b0;
    #1;
    chk("async_bus_valid", 32'(bus_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_done_in_rst", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    step();
    run_cmd(8'h09, 8'h03, 24'h654321, 4, 1'b0, 0, 1'b0, 1'b0);

    ops = '{8'h02, 8'h03, 8'h20, 8'h52, 8'hD8, 8'h99, 8'h00};
    for (int n = 0; n < 14; n++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == 8'h00) op = 8'($urandom);
      run_cmd(8'($urandom), op, 24'($urandom), int'($urandom_range(0, T + 2)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
